// File: rtl/pwm_pkg.sv
// Shared types and constants for the pwm compare path.
// cmp_t is the compare word width used by both the slew stage and pwm cmpA.
package pwm_pkg;

  localparam int CMP_W = 18;

  typedef logic [CMP_W-1:0] cmp_t;

  localparam cmp_t CMP_RESET = 18'h01342;

  typedef enum logic {
    IDLE = 1'b0,
    SLEW = 1'b1
  } slew_state_e;

  // Kept as a function so clamp bounds of zero / all-ones don't fold into constant compares.
  function automatic cmp_t clamp_cmp(input cmp_t value, input cmp_t lo, input cmp_t hi);
    cmp_t result;
    result = value;
    if (result < lo) result = lo;
    if (result > hi) result = hi;
    return result;
  endfunction

endpackage

// File: rtl/pwm_cmp_step.sv
// One slew step: moves cmp toward tgt by at most step (step of zero jumps straight to tgt).
module pwm_cmp_step
  import pwm_pkg::*;
#(
  parameter int STEP_W = 8
) (
  input  cmp_t              cmp,
  input  cmp_t              tgt,
  input  logic [STEP_W-1:0] step,
  output cmp_t              next_cmp
);

  logic signed [CMP_W:0] diff;
  logic        [CMP_W:0] abs_diff;
  logic        [CMP_W:0] step_ext;

  // The extra sign bit keeps the difference exact across the full unsigned range.
  assign diff     = $signed({1'b0, tgt}) - $signed({1'b0, cmp});
  assign abs_diff = diff[CMP_W] ? CMP_W'(0) - diff : diff;
  assign step_ext = {{(CMP_W + 1 - STEP_W){1'b0}}, step};

  always_comb begin
    next_cmp = tgt;
    if ((step != '0) && (abs_diff > step_ext)) begin
      if (diff[CMP_W]) next_cmp = cmp - step_ext[CMP_W-1:0];
      else             next_cmp = cmp + step_ext[CMP_W-1:0];
    end
  end

endmodule

// File: rtl/pwm_cmp_slew.sv
// Slew-limited compare word for pwm cmpA: targets arrive over valid/ready and
// the live compare moves toward them only on PWM period strobes.
module pwm_cmp_slew
  import pwm_pkg::*;
#(
  parameter int   STEP_W    = 8,
  parameter cmp_t CMP_RESET = pwm_pkg::CMP_RESET,
  parameter cmp_t CMP_MIN   = 18'h00000,
  parameter cmp_t CMP_MAX   = 18'h3FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  cmp_t              tgt_data,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [STEP_W-1:0] step,
  input  logic              period_stb,
  output cmp_t              cmp_out,
  output logic              cmp_upd,
  output logic              at_target
);

  cmp_t        clamped;
  cmp_t        pend_data;
  cmp_t        act_tgt;
  cmp_t        cmp_q;
  cmp_t        new_tgt;
  cmp_t        cmp_next;
  logic        pend_full;
  logic        upd_q;
  logic        accept;
  slew_state_e state;
  slew_state_e state_next;

  assign tgt_ready = ~pend_full;
  assign accept    = tgt_valid & tgt_ready;
  assign clamped   = clamp_cmp(tgt_data, CMP_MIN, CMP_MAX);

  // A pending value wins; otherwise a same-cycle accept bypasses the slot.
  always_comb begin
    new_tgt = act_tgt;
    if (pend_full)   new_tgt = pend_data;
    else if (accept) new_tgt = clamped;
  end

  pwm_cmp_step #(.STEP_W(STEP_W)) u_step (
    .cmp      (cmp_q),
    .tgt      (new_tgt),
    .step     (step),
    .next_cmp (cmp_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q     <= CMP_RESET;
      act_tgt   <= CMP_RESET;
      pend_data <= '0;
      pend_full <= 1'b0;
      upd_q     <= 1'b0;
    end else if (period_stb) begin
      act_tgt   <= new_tgt;
      cmp_q     <= cmp_next;
      pend_full <= 1'b0;
      upd_q     <= (cmp_next != cmp_q);
    end else begin
      upd_q <= 1'b0;
      if (accept) begin
        pend_data <= clamped;
        pend_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (period_stb) begin
      state_next = (cmp_next == new_tgt) ? IDLE : SLEW;
    end else if (pend_full || accept) begin
      state_next = SLEW;
    end
  end

  assign cmp_out   = cmp_q;
  assign cmp_upd   = upd_q;
  assign at_target = (cmp_q == act_tgt) && !pend_full;

endmodule

// File: tb/tb_pwm_cmp_slew.sv
// Directed bench for pwm_cmp_slew; a second instance carries narrowed clamp bounds.
module tb_pwm_cmp_slew;
  import pwm_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  cmp_t       tgt_data;
  logic       tgt_valid;
  logic [7:0] step;
  logic       period_stb;

  logic tgt_ready, cmp_upd, at_target;
  cmp_t cmp_out;
  logic c_tgt_ready, c_cmp_upd, c_at_target;
  cmp_t c_cmp_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_cmp_slew dut (
    .clk        (clk),
    .rst        (rst),
    .tgt_data   (tgt_data),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .step       (step),
    .period_stb (period_stb),
    .cmp_out    (cmp_out),
    .cmp_upd    (cmp_upd),
    .at_target  (at_target)
  );

  pwm_cmp_slew #(.CMP_MIN(18'h00100), .CMP_MAX(18'h02000)) dut_c (
    .clk        (clk),
    .rst        (rst),
    .tgt_data   (tgt_data),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (c_tgt_ready),
    .step       (step),
    .period_stb (period_stb),
    .cmp_out    (c_cmp_out),
    .cmp_upd    (c_cmp_upd),
    .at_target  (c_at_target)
  );

  task automatic checkOutput(input string tag, input logic [17:0] observed, input logic [17:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input cmp_t data, input logic stb, input logic [7:0] stp);
    tgt_valid  = valid;
    tgt_data   = data;
    period_stb = stb;
    step       = stp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 8'd16);
    tick();
    tick();
    rst = 1'b0;
    tick();

    checkOutput("reset cmp_out", cmp_out, 18'h01342);
    checkOutput("reset tgt_ready", 18'(tgt_ready), 18'd1);
    checkOutput("reset at_target", 18'(at_target), 18'd1);
    checkOutput("reset cmp_upd", 18'(cmp_upd), 18'd0);

    applyStimulus(1'b0, '0, 1'b1, 8'd16);
    for (int i = 0; i < 100; i++) begin
      tick();
      checkOutput("idle strobe cmp_out", cmp_out, 18'h01342);
      checkOutput("idle strobe cmp_upd", 18'(cmp_upd), 18'd0);
    end

    applyStimulus(1'b1, 18'h01382, 1'b0, 8'd16);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 8'd16);
    checkOutput("slew accept ready low", 18'(tgt_ready), 18'd0);
    checkOutput("slew accept at_target", 18'(at_target), 18'd0);
    checkOutput("slew accept cmp hold", cmp_out, 18'h01342);
    applyStimulus(1'b0, '0, 1'b1, 8'd16);
    tick(); checkOutput("slew s1 cmp", cmp_out, 18'h01352); checkOutput("slew s1 upd", 18'(cmp_upd), 18'd1);
    tick(); checkOutput("slew s2 cmp", cmp_out, 18'h01362); checkOutput("slew s2 upd", 18'(cmp_upd), 18'd1);
    tick(); checkOutput("slew s3 cmp", cmp_out, 18'h01372); checkOutput("slew s3 at_target", 18'(at_target), 18'd0);
    tick(); checkOutput("slew s4 cmp", cmp_out, 18'h01382); checkOutput("slew s4 upd", 18'(cmp_upd), 18'd1);
    checkOutput("slew s4 at_target", 18'(at_target), 18'd1);
    applyStimulus(1'b0, '0, 1'b0, 8'd16);
    tick();
    checkOutput("slew settled upd", 18'(cmp_upd), 18'd0);
    checkOutput("slew settled cmp", cmp_out, 18'h01382);

    pulseReset();
    applyStimulus(1'b1, 18'h01347, 1'b0, 8'd16);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 8'd16);
    tick();
    checkOutput("small diff cmp", cmp_out, 18'h01347);
    checkOutput("small diff at_target", 18'(at_target), 18'd1);
    applyStimulus(1'b1, 18'h03000, 1'b0, 8'd0);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 8'd0);
    tick();
    checkOutput("step0 jump cmp", cmp_out, 18'h03000);
    checkOutput("step0 jump upd", 18'(cmp_upd), 18'd1);

    applyStimulus(1'b1, 18'h03010, 1'b1, 8'd0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 8'd0);
    checkOutput("bypass cmp", cmp_out, 18'h03010);
    checkOutput("bypass ready", 18'(tgt_ready), 18'd1);
    checkOutput("bypass at_target", 18'(at_target), 18'd1);

    applyStimulus(1'b1, 18'h02000, 1'b0, 8'd0);
    tick();
    checkOutput("hs A ready low", 18'(tgt_ready), 18'd0);
    applyStimulus(1'b1, 18'h02100, 1'b0, 8'd0);
    tick();
    tick();
    checkOutput("hs B held ready", 18'(tgt_ready), 18'd0);
    checkOutput("hs cmp stable", cmp_out, 18'h03010);
    applyStimulus(1'b1, 18'h02100, 1'b1, 8'd0);
    tick();
    checkOutput("hs strobe applies A", cmp_out, 18'h02000);
    checkOutput("hs drained ready", 18'(tgt_ready), 18'd1);
    applyStimulus(1'b1, 18'h02100, 1'b0, 8'd0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 8'd0);
    checkOutput("hs B accepted", 18'(tgt_ready), 18'd0);
    checkOutput("hs cmp still A", cmp_out, 18'h02000);
    applyStimulus(1'b0, '0, 1'b1, 8'd0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 8'd0);
    checkOutput("hs strobe applies B", cmp_out, 18'h02100);
    checkOutput("hs B at_target", 18'(at_target), 18'd1);

    pulseReset();
    applyStimulus(1'b1, 18'h01382, 1'b0, 8'd16);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 8'd16);
    tick();
    tick();
    checkOutput("midslew cmp", cmp_out, 18'h01362);
    applyStimulus(1'b1, 18'h01500, 1'b0, 8'd16);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 8'd16);
    checkOutput("midslew pend full", 18'(tgt_ready), 18'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst cmp", cmp_out, 18'h01342);
    checkOutput("async rst ready", 18'(tgt_ready), 18'd1);
    checkOutput("async rst at_target", 18'(at_target), 18'd1);
    checkOutput("async rst upd", 18'(cmp_upd), 18'd0);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b1, 8'd16);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 8'd16);
    checkOutput("post rst pend discarded", cmp_out, 18'h01342);
    checkOutput("post rst no upd", 18'(cmp_upd), 18'd0);

    pulseReset();
    applyStimulus(1'b1, 18'h3FFFF, 1'b0, 8'hFF);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 8'hFF);
    tick();
    checkOutput("clamp hi first step", c_cmp_out, 18'h01441);
    repeat (19) tick();
    checkOutput("clamp hi stop", c_cmp_out, 18'h02000);
    checkOutput("clamp hi at_target", 18'(c_at_target), 18'd1);
    applyStimulus(1'b1, 18'h00000, 1'b0, 8'hFF);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 8'hFF);
    repeat (40) tick();
    applyStimulus(1'b0, '0, 1'b0, 8'hFF);
    checkOutput("clamp lo stop", c_cmp_out, 18'h00100);
    checkOutput("clamp lo at_target", 18'(c_at_target), 18'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
